// File: rtl/m_serial_tx.sv
// Parallel-to-serial transmitter: accepts a D_N-bit word on a valid/ready
// handshake and sends it LSB first, followed by one even-parity bit.
module m_serial_tx #(
  parameter int D_N = 32
) (
  input  logic           w_clk,
  input  logic           w_rst_n,
  input  logic [D_N-1:0] w_din,
  input  logic           w_valid,
  output logic           w_ready,
  output logic           w_sout,
  output logic           w_sframe,
  output logic           w_spar
);

  localparam int             CW   = $clog2(D_N) + 1;
  localparam logic [CW-1:0]  LAST = CW'(D_N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PAR
  } state_e;

  state_e          state_q, state_d;
  logic [D_N-1:0]  r_sh_q, r_sh_d;
  logic            r_par_q, r_par_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sout_q, sout_d;
  logic            sframe_q, sframe_d;
  logic            spar_q, spar_d;
  logic            accept;

  // Ready depends on state alone, so the producer never sees a loop through valid.
  assign w_ready = (state_q != S_DATA);
  assign accept  = w_valid && w_ready;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    r_sh_d  = r_sh_q;
    r_par_d = r_par_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE, S_PAR: begin
        if (accept) begin
          state_d = S_DATA;
          r_sh_d  = w_din;
          r_par_d = ^w_din;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        r_sh_d = r_sh_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = S_PAR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Serial outputs are computed from the next state and registered, so the
    // pins are pure flop outputs and bit 0 appears the cycle after accept.
    sframe_d = (state_d == S_DATA);
    spar_d   = (state_d == S_PAR);
    if (sframe_d) begin
      sout_d = r_sh_d[0];
    end else if (spar_d) begin
      sout_d = r_par_d;
    end else begin
      sout_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q  <= S_IDLE;
      r_sh_q   <= '0;
      r_par_q  <= 1'b0;
      cnt_q    <= '0;
      sout_q   <= 1'b0;
      sframe_q <= 1'b0;
      spar_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_sh_q   <= r_sh_d;
      r_par_q  <= r_par_d;
      cnt_q    <= cnt_d;
      sout_q   <= sout_d;
      sframe_q <= sframe_d;
      spar_q   <= spar_d;
    end
  end

  assign w_sout   = sout_q;
  assign w_sframe = sframe_q;
  assign w_spar   = spar_q;

endmodule

// File: doc/m_serial_tx.md
# m_serial_tx

Parallel-to-serial transmitter for the shift-register operand links. Accepts a `D_N`-bit word over a valid/ready handshake and shifts it out one bit per clock, LSB first, then one even-parity bit. Its framing matches a receiver that, on every `w_sframe` cycle, loads `{w_sout, r[D_N-1:1]}`: after `D_N` framed cycles that receiver holds the original word. The block sits at the output end of a datapath, e.g. returning adder sums to the serial test harness.

## Interface
- `D_N`, default 32: data word width in bits; must be at least 2.
- `w_clk`  in  1: the only clock; every register updates on its rising edge.
- `w_rst_n`  in  1: asynchronous, active-low reset.
- `w_din`  in  `D_N`: parallel word; sampled only on an accepted handshake.
- `w_valid`  in  1: producer has a word on `w_din`.
- `w_ready`  out  1: transmitter can accept a word this cycle.
- `w_sout`  out  1: serial data; a data bit during the frame, the parity bit in the parity cycle.
- `w_sframe`  out  1: high exactly while `w_sout` carries a data bit.
- `w_spar`  out  1: high exactly while `w_sout` carries the parity bit.

## Operation
- States:
  - IDLE: no transmission in progress.
  - DATA: shifting out the `D_N` data bits.
  - PAR: sending the parity bit.
- Accept means `w_valid && w_ready` at a rising edge. On accept, the block latches:
  - `w_din` into shift register `r_sh`;
  - `^w_din` into `r_par`;
  - bit counter := 0.
- `w_ready` is a combinational function of state only: 1 in IDLE and PAR, 0 in DATA. It never depends on `w_valid`.
- IDLE:
  - accept → DATA;
  - otherwise stay in IDLE.
- DATA, each cycle:
  - `w_sout` = `r_sh[0]`;
  - on the clock edge, `r_sh` shifts right with 0 fill and the counter increments;
  - when the counter reaches `D_N-1` → PAR.
- PAR:
  - `w_sout` = `r_par`;
  - accept → DATA, with no idle cycle between words;
  - otherwise → IDLE.
- Parity is even: the XOR over the `D_N` data bits plus the parity bit is 0.
- The counter is `$clog2(D_N)+1` bits wide. It never wraps, because the state changes before overflow.
- `w_valid` asserted during DATA is not an error. The word is held off, not lost, and is accepted at the next IDLE or PAR cycle.
- `w_din` changing while `w_ready`=0 has no effect.

## Timing
- All serial outputs (`w_sout`, `w_sframe`, `w_spar`) are driven directly from registers; no combinational path from inputs reaches them.
- Values while `w_rst_n`=0 and after reset:
  - state = IDLE;
  - `w_ready`=1, `w_sout`=0, `w_sframe`=0, `w_spar`=0;
  - `r_sh`=0, `r_par`=0, counter=0.
- Reset asserted mid-frame: all outputs drop to their reset values immediately (asynchronously). The partial word is discarded and not resumed.
- Latency: the word accepted at edge t appears as follows.
  - Bit i (i = 0 … `D_N-1`) is on `w_sout` with `w_sframe`=1 in cycle t+1+i.
  - The parity bit is on `w_sout` with `w_spar`=1 in cycle t+1+`D_N`.
- Throughput:
  - with continuous `w_valid`, one word per `D_N+1` cycles;
  - `w_sframe` is low for exactly one cycle between consecutive frames.
- `w_sframe` and `w_spar` are never high in the same cycle.
- Outside a frame or parity cycle, `w_sout` is 0.
- Simultaneous events:
  - accept in PAR: the current parity bit is still output in that cycle, and the new word's bit 0 follows in the next cycle;
  - reset deassertion concurrent with `w_valid`=1: the word is accepted at the first rising edge with `w_rst_n`=1.

## Test plan
- Reset, then `w_din`=45 with a single-cycle `w_valid`:
  - `w_sframe` high for 32 cycles;
  - `w_sout` sequence 1,0,1,1,0,1 followed by 26 zeros;
  - then `w_spar`=1 with `w_sout`=0;
  - then IDLE with `w_ready`=1.
- Back-to-back words 34 then 0x00000001, with `w_valid` held high:
  - second accept occurs in the PAR cycle of the first word;
  - parity bits are 0 then 1;
  - frames are separated by exactly one non-frame cycle;
  - total 66 cycles.
- Word 0xFFFFFFFF: 32 ones, then parity 0. A model receiver shifting on `w_sframe` holds 0xFFFFFFFF after the frame.
- `w_valid` held from cycle 5 of a frame onward, while `w_din` toggles between 0xA5A5A5A5 and 0x12345678 during DATA:
  - `w_ready`=0 throughout DATA;
  - the word accepted is the value of `w_din` in the PAR cycle;
  - the receiver reproduces that value exactly.
- `w_rst_n` pulsed low at bit 10 of a 0xDEADBEEF frame:
  - all outputs go to 0 at once and `w_ready`=1;
  - no parity cycle occurs;
  - the next word, 0x00000003, transmits cleanly with parity 0.
- Random regression with `D_N`=8, 1000 words, random `w_valid` gaps: every received word and parity matches the scoreboard, and no word is dropped or duplicated.
